// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per clock.
// Stalls the pipeline while busy and presents {remainder, quotient} in END.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d;
    logic               negq_q, negq_d, negr_q, negr_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               go, last, ge;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   rem_n, quo_n, abs1, abs2;

    assign go    = start_i & ~annul_i;
    assign last  = cnt_q == CW'(WIDTH - 1);
    // Two guard bits keep the borrow exact even when the shifted remainder exceeds 2^WIDTH.
    assign diff  = {1'b0, rem_q, dvd_q[WIDTH-1]} - {2'b0, dvs_q};
    assign ge    = ~diff[WIDTH+1];
    assign rem_n = ge ? diff[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    assign quo_n = {dvd_q[WIDTH-2:0], ge};
    assign abs1  = (signed_div_i & opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs2  = (signed_div_i & opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FREE:   state_d = !go ? S_FREE : (opdata2_i == '0 ? S_BYZERO : S_ON);
            S_BYZERO: state_d = annul_i ? S_FREE : S_END;
            S_ON:     state_d = annul_i ? S_FREE : (last ? S_END : S_ON);
            S_END:    state_d = (annul_i | ~start_i) ? S_FREE : S_END;
            default:  state_d = S_FREE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        if (state_q == S_FREE && go && opdata2_i != '0) begin
            dvd_d  = abs1;
            dvs_d  = abs2;
            rem_d  = '0;
            cnt_d  = '0;
            negq_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            negr_d = signed_div_i & opdata1_i[WIDTH-1];
        end
        if (state_q == S_ON && !annul_i) begin
            rem_d = rem_n;
            dvd_d = quo_n;
            cnt_d = cnt_q + 1'b1;
            if (last)
                result_d = {negr_q ? -rem_n : rem_n, negq_q ? -quo_n : quo_n};
        end
        if (state_q == S_BYZERO || state_d == S_FREE)
            result_d = '0;
        if (state_d == S_FREE)
            cnt_d = '0;
    end

    always_comb begin
        ready_o    = state_q == S_END;
        stallreq_o = start_i & ~ready_o;
    end

    assign result_o = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed test of div_unit against a cycle-budget reference model
// and hand-computed quotient/remainder literals.
module tb_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         signed_div = 1'b0;
    logic         start = 1'b0;
    logic         annul = 1'b0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [2*W-1:0] result;
    logic         ready, stall;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div),
        .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
        .result_o(result), .ready_o(ready), .stallreq_o(stall)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Plain-arithmetic reference: {remainder, quotient}, zero on divide by zero.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        if (b == 0) return 64'd0;
        if (!s) return {a % b, a / b};
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q = ma / mb;
        r = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
    endfunction

    // Model tracks only how many cycles remain until ready and what the answer must be.
    logic        m_busy = 1'b0, m_rdy = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res = '0, m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_rdy  <= 1'b0;
            m_left <= 0;
        end else if (m_rdy) begin
            if (annul | ~start) m_rdy <= 1'b0;
        end else if (m_busy) begin
            if (annul) m_busy <= 1'b0;
            else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_rdy  <= 1'b1;
                m_res  <= m_pend;
            end else m_left <= m_left - 1;
        end else if (start & ~annul) begin
            m_busy <= 1'b1;
            m_left <= (op2 == 0) ? 1 : W;
            m_pend <= ref_div(signed_div, op1, op2);
        end
    end

    always @(negedge clk) begin
        chk("ready", 64'(ready), 64'(m_rdy));
        chk("stallreq", 64'(stall), 64'(start & ~m_rdy));
        if (m_rdy) chk("result", result, m_res);
        else if (!m_busy) chk("idle_result", result, 64'd0);
    end

    task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int exp_cyc, input int hold);
        int n;
        @(posedge clk); #1;
        signed_div = s; op1 = a; op2 = b; start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin op1 = ~a; signed_div = ~s; end
        end while (!ready && n < 40);
        if (!ready) $display("FAIL timeout: ready never rose for %h / %h", a, b);
        chk("latency", 64'(n), 64'(exp_cyc));
        chk("value", result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_value", result, exp);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("clear_ready", 64'(ready), 64'd0);
        chk("clear_result", result, 64'd0);
    endtask

    initial begin
        chk("model_pin_divu", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model_pin_div", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);

        run(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 0);
        run(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
        run(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 33, 0);
        run(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h3}, 33, 0);
        run(1'b0, 32'd5, 32'd0, 64'd0, 2, 0);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 0);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33, 0);
        run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'h1, 32'h1}, 33, 0);

        // Abort in cycle 10, then a fresh divide.
        @(posedge clk); #1;
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        chk("annul_ready", 64'(ready), 64'd0);
        repeat (3) begin @(posedge clk); #1; chk("annul_no_ready", 64'(ready), 64'd0); end
        run(1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33, 0);

        // Reset in cycle 20.
        @(posedge clk); #1;
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_result", result, 64'd0);

        // Hold in END for 3 cycles, then release.
        run(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33, 3);
        run(1'b1, 32'hFFFF_FF9C, 32'd0, 64'd0, 2, 2);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
